nbr_coord_gen: RTL and testbench

- Sequential neighbourhood coordinate generator for the cellular-grid engine.
- Accepts one cell coordinate (x, y) per request and streams the coordinates of every cell in its (2R+1)x(2R+1) window, one per handshake.
- Each output is bounded against the runtime grid size, either toroidally wrapped or flagged out-of-bounds.
- Sits between the cell scheduler and the grid-memory read port; generalises the single-offset wrap logic to any radius, any coordinate width and two boundary modes.

---
 rtl/nbr_coord_gen_pkg.sv | 21 ++
 rtl/nbr_coord_gen_if.sv | 37 +++
 rtl/nbr_coord_gen_bound.sv | 38 +++
 rtl/nbr_coord_gen.sv | 134 +++++++++++++
 tb/tb_nbr_coord_gen.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nbr_coord_gen_pkg.sv
// Shared neighbourhood-generator definitions: FSM state type and the
// radius-derived window size / index width helpers used by the scheduler too.
package nbr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } nbr_state_e;

  // Signed offset width; holds -7..+7 for the full legal radius range.
  localparam int unsigned OFF_W = 4;

  function automatic int unsigned nbr_num(input int unsigned radius);
    return (2 * radius + 1) * (2 * radius + 1);
  endfunction

  function automatic int unsigned idx_w(input int unsigned radius);
    return $clog2(nbr_num(radius));
  endfunction

endpackage

// File: rtl/nbr_coord_gen_if.sv
// Request/response bundle between the cell scheduler (master) and the
// neighbourhood coordinate generator (slave).
interface nbr_coord_gen_if
  import nbr_pkg::*;
#(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned RADIUS  = 1
) ();

  localparam int unsigned IDX_W = idx_w(RADIUS);

  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;
  logic [COORD_W-1:0] total_rows;
  logic [COORD_W-1:0] total_cols;
  logic               wrap_mode;
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [IDX_W-1:0]   out_idx;
  logic               out_oob;
  logic               out_last;

  modport master (
    output req_valid, req_x, req_y, total_rows, total_cols, wrap_mode, out_ready,
    input  req_ready, out_valid, out_x, out_y, out_idx, out_oob, out_last
  );

  modport slave (
    input  req_valid, req_x, req_y, total_rows, total_cols, wrap_mode, out_ready,
    output req_ready, out_valid, out_x, out_y, out_idx, out_oob, out_last
  );

endinterface

// File: rtl/nbr_coord_gen_bound.sv
// Single-axis bound: coord + signed offset, either wrapped once into [0,N)
// or flagged out-of-bounds for dead-border grids.
module nbr_bound
  import nbr_pkg::*;
#(
  parameter int unsigned COORD_W = 8
) (
  input  logic [COORD_W-1:0]      coord_i,
  input  logic signed [OFF_W-1:0] off_i,
  input  logic [COORD_W-1:0]      size_i,
  input  logic                    wrap_i,
  output logic [COORD_W-1:0]      value_o,
  output logic                    oob_o
);

  localparam int unsigned SW = COORD_W + 2;

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] size_s;
  logic                 under;
  logic                 over;

  always_comb begin
    size_s = $signed({2'b00, size_i});
    sum    = $signed({2'b00, coord_i}) + $signed({{(SW-OFF_W){off_i[OFF_W-1]}}, off_i});
    under  = sum[SW-1];
    over   = !under && (sum >= size_s);
    // Low bits suffice for the +/-N correction: the true result fits COORD_W.
    value_o = sum[COORD_W-1:0];
    if (wrap_i && under) begin
      value_o = sum[COORD_W-1:0] + size_i;
    end else if (wrap_i && over) begin
      value_o = sum[COORD_W-1:0] - size_i;
    end
    oob_o = !wrap_i && (under || over);
  end

endmodule

// File: rtl/nbr_coord_gen.sv
// Streams the (2R+1)^2 neighbour coordinates of one cell, wrapped or border-flagged.
// Optional macro NBR_SKIP_CENTER_EN drops the centre offset (0,0) from the stream.
module nbr_coord_gen
  import nbr_pkg::*;
#(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned RADIUS  = 1
) (
  input logic          clk,
  input logic          resetn,
  nbr_coord_gen_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(RADIUS);
  localparam logic signed [OFF_W-1:0] R_POS   = OFF_W'(RADIUS);
  localparam logic signed [OFF_W-1:0] R_NEG   = -R_POS;
  localparam logic signed [OFF_W-1:0] OFF_ONE = OFF_W'(1);

  nbr_state_e         state_q;
  logic               req_ready_q, out_valid_q, out_oob_q, out_last_q, wrap_q;
  logic [COORD_W-1:0] x_q, y_q, rows_q, cols_q, out_x_q, out_y_q;
  logic [IDX_W-1:0]   idx_q;
  logic signed [OFF_W-1:0] dx_q, dy_q, dx_d, dy_d;

  logic [COORD_W-1:0] src_x, src_y, src_rows, src_cols, bx_val, by_val;
  logic               src_wrap, bx_oob, by_oob, oob_any, last_d, load;

  // Next offset and its bounded coordinates are computed ahead so every output is a flop.
  always_comb begin
    dx_d     = R_NEG;
    dy_d     = R_NEG;
    src_x    = bus.req_x;
    src_y    = bus.req_y;
    src_rows = bus.total_rows;
    src_cols = bus.total_cols;
    src_wrap = bus.wrap_mode;
    if (state_q == RUN) begin
      src_x    = x_q;
      src_y    = y_q;
      src_rows = rows_q;
      src_cols = cols_q;
      src_wrap = wrap_q;
      dx_d     = dx_q;
      dy_d     = dy_q + OFF_ONE;
      if (dy_q == R_POS) begin
        dy_d = R_NEG;
        dx_d = dx_q + OFF_ONE;
      end
`ifdef NBR_SKIP_CENTER_EN
      if (dx_d == '0 && dy_d == '0) begin
        dy_d = OFF_ONE;
      end
`endif
    end
    last_d  = (dx_d == R_POS) && (dy_d == R_POS);
    oob_any = bx_oob || by_oob;
    load    = (state_q == IDLE) ? bus.req_valid : (bus.out_ready && !out_last_q);
  end

  nbr_bound #(.COORD_W(COORD_W)) u_bound_x (
    .coord_i(src_x), .off_i(dx_d), .size_i(src_rows), .wrap_i(src_wrap),
    .value_o(bx_val), .oob_o(bx_oob)
  );

  nbr_bound #(.COORD_W(COORD_W)) u_bound_y (
    .coord_i(src_y), .off_i(dy_d), .size_i(src_cols), .wrap_i(src_wrap),
    .value_o(by_val), .oob_o(by_oob)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      idx_q       <= '0;
      out_oob_q   <= 1'b0;
      out_last_q  <= 1'b0;
      dx_q        <= '0;
      dy_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      wrap_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            x_q         <= bus.req_x;
            y_q         <= bus.req_y;
            rows_q      <= bus.total_rows;
            cols_q      <= bus.total_cols;
            wrap_q      <= bus.wrap_mode;
            idx_q       <= '0;
            state_q     <= RUN;
            req_ready_q <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              req_ready_q <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (load) begin
        dx_q       <= dx_d;
        dy_q       <= dy_d;
        out_x_q    <= oob_any ? '0 : bx_val;
        out_y_q    <= oob_any ? '0 : by_val;
        out_oob_q  <= oob_any;
        out_last_q <= last_d;
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_oob   = out_oob_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_nbr_coord_gen.sv
// Scoreboard bench for nbr_coord_gen: a window-enumerating reference model
// queues expected neighbours per request; a negedge monitor pops and compares.
module tb_nbr_coord_gen;

  localparam int unsigned COORD_W = 8;
`ifdef NBR_SKIP_CENTER_EN
  localparam int RADIUS = 2;
  localparam bit SKIP   = 1'b1;
`else
  localparam int RADIUS = 1;
  localparam bit SKIP   = 1'b0;
`endif
  localparam int unsigned IDX_W = nbr_pkg::idx_w(RADIUS);

  typedef struct {
    int x;
    int y;
    int idx;
    bit oob;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  nbr_coord_gen_if #(.COORD_W(COORD_W), .RADIUS(RADIUS)) bus ();

  nbr_coord_gen #(.COORD_W(COORD_W), .RADIUS(RADIUS)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned rdy_pct = 100;
  int          stall_idx = -1;
  int          stall_left = 0;
  bit          held = 1'b0;
  bit          idle_chk = 1'b0;
  int          h_x, h_y, h_idx;
  bit          h_oob, h_last;

  task automatic chk(input bit ok, input string name, input string act, input string req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %s required %s", name, act, req);
    end
  endtask

  // Reference: enumerate the window directly and bound each cell with modulo arithmetic.
  task automatic expect_req(input int x, input int y, input int nr, input int nc, input bit wrap);
    int k;
    k = 0;
    for (int dx = -RADIUS; dx <= RADIUS; dx++) begin
      for (int dy = -RADIUS; dy <= RADIUS; dy++) begin
        exp_t e;
        int sx, sy;
        if (SKIP && dx == 0 && dy == 0) continue;
        sx    = x + dx;
        sy    = y + dy;
        e.oob = !wrap && (sx < 0 || sx >= nr || sy < 0 || sy >= nc);
        if (wrap) begin
          e.x = ((sx % nr) + nr) % nr;
          e.y = ((sy % nc) + nc) % nc;
        end else if (e.oob) begin
          e.x = 0;
          e.y = 0;
        end else begin
          e.x = sx;
          e.y = sy;
        end
        e.idx  = k;
        e.last = (dx == RADIUS) && (dy == RADIUS);
        k++;
        sb.push_back(e);
      end
    end
  endtask

  task automatic scramble_cfg();
    bus.req_x      = COORD_W'($urandom);
    bus.req_y      = COORD_W'($urandom);
    bus.total_rows = COORD_W'($urandom);
    bus.total_cols = COORD_W'($urandom);
    bus.wrap_mode  = 1'($urandom);
  endtask

  task automatic wait_ready();
    int c;
    c = 0;
    while (!bus.req_ready && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (!bus.req_ready) chk(1'b0, "req_ready_timeout", "0", "1");
  endtask

  task automatic issue(input int x, input int y, input int nr, input int nc, input bit wrap);
    wait_ready();
    bus.req_valid  = 1'b1;
    bus.req_x      = COORD_W'(x);
    bus.req_y      = COORD_W'(y);
    bus.total_rows = COORD_W'(nr);
    bus.total_cols = COORD_W'(nc);
    bus.wrap_mode  = wrap;
    expect_req(x, y, nr, nc, wrap);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    scramble_cfg();
  endtask

  task automatic send(input int x, input int y, input int nr, input int nc, input bit wrap,
                      input int unsigned pct);
    int c;
    rdy_pct = pct;
    issue(x, y, nr, nc, wrap);
    c = 0;
    // Noise on req_valid and config while running must be ignored.
    while (sb.size() != 0 && c < 400) begin
      @(posedge clk);
      #1;
      c++;
      if (sb.size() != 0) begin
        bus.req_valid = 1'($urandom);
        scramble_cfg();
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    if (sb.size() != 0) begin
      chk(1'b0, "stream_timeout", $sformatf("%0d left", sb.size()), "0 left");
      sb.delete();
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && bus.out_valid && int'(bus.out_idx) == stall_idx) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        held     = 1'b0;
        idle_chk = 1'b0;
      end else begin
        if (idle_chk) begin
          idle_chk = 1'b0;
          chk(bus.req_ready && !bus.out_valid, "idle_after_last",
              $sformatf("rdy=%0b vld=%0b", bus.req_ready, bus.out_valid), "rdy=1 vld=0");
        end
        if (bus.out_valid) begin
          if (held) begin
            chk(int'(bus.out_x) == h_x && int'(bus.out_y) == h_y && int'(bus.out_idx) == h_idx &&
                bus.out_oob == h_oob && bus.out_last == h_last, "hold_stable",
                $sformatf("(%0d,%0d) idx%0d", bus.out_x, bus.out_y, bus.out_idx),
                $sformatf("(%0d,%0d) idx%0d", h_x, h_y, h_idx));
          end
          if (bus.out_ready) begin
            held = 1'b0;
            if (sb.size() == 0) begin
              chk(1'b0, "unexpected_output", $sformatf("idx%0d", bus.out_idx), "none");
            end else begin
              exp_t e;
              e = sb.pop_front();
              chk(int'(bus.out_x) == e.x && int'(bus.out_y) == e.y && int'(bus.out_idx) == e.idx &&
                  bus.out_oob == e.oob && bus.out_last == e.last && !bus.req_ready, "nbr_output",
                  $sformatf("x=%0d y=%0d idx=%0d oob=%0b last=%0b rdy=%0b", bus.out_x, bus.out_y,
                            bus.out_idx, bus.out_oob, bus.out_last, bus.req_ready),
                  $sformatf("x=%0d y=%0d idx=%0d oob=%0b last=%0b rdy=0", e.x, e.y, e.idx,
                            e.oob, e.last));
              if (e.last) idle_chk = 1'b1;
            end
          end else begin
            held   = 1'b1;
            h_x    = int'(bus.out_x);
            h_y    = int'(bus.out_y);
            h_idx  = int'(bus.out_idx);
            h_oob  = bus.out_oob;
            h_last = bus.out_last;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    resetn        = 1'b0;
    bus.req_valid = 1'b0;
    scramble_cfg();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(bus.req_ready && !bus.out_valid && bus.out_x == '0 && bus.out_y == '0 &&
        bus.out_idx == '0 && !bus.out_oob && !bus.out_last, "reset_state",
        $sformatf("rdy=%0b vld=%0b x=%0d y=%0d idx=%0d oob=%0b last=%0b", bus.req_ready,
                  bus.out_valid, bus.out_x, bus.out_y, bus.out_idx, bus.out_oob, bus.out_last),
        "rdy=1 vld=0 x=0 y=0 idx=0 oob=0 last=0");
    resetn = 1'b1;

    send(0, 0, 8, 8, 1'b1, 100);
    send(0, 0, 8, 8, 1'b0, 100);
    send(7, 4, 8, 5, 1'b1, 100);
    stall_idx  = 3;
    stall_left = 3;
    send(3, 3, 8, 8, 1'b1, 100);
    stall_left = 0;

    // Abort a request mid-stream with a one-cycle reset pulse.
    rdy_pct = 100;
    issue(4, 4, 8, 8, 1'b1);
    c = 0;
    while (!(bus.out_valid && int'(bus.out_idx) == 5) && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= 50) chk(1'b0, "reach_idx5_timeout", "not reached", "idx5");
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    sb.delete();
    @(negedge clk);
    chk(!bus.out_valid && bus.req_ready, "reset_abort",
        $sformatf("vld=%0b rdy=%0b", bus.out_valid, bus.req_ready), "vld=0 rdy=1");
    send(2, 2, 8, 8, 1'b1, 100);

    if (SKIP) send(8, 8, 16, 16, 1'b1, 100);
    send(254, 254, 255, 255, 1'b1, 80);
    send(0, 254, 255, 255, 1'b0, 80);
    send(254, 0, 255, 255, 1'b0, 80);

    for (int i = 0; i < 20; i++) begin
      int nr, nc;
      nr = int'($urandom_range(RADIUS + 1, 255));
      nc = int'($urandom_range(RADIUS + 1, 255));
      send(int'($urandom_range(0, nr - 1)), int'($urandom_range(0, nc - 1)), nr, nc,
           1'($urandom), $urandom_range(40, 100));
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
